// File: rtl/spram_req_ctrl_if.sv
// Request/response handshake bundle between a requester and spram_req_ctrl.
// master = requester side, slave = controller side.
interface spram_req_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_wr;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/spram_req_ctrl.sv
// Requester front-end for a 2-cycle-latency single-port RAM: forwards requests,
// tracks in-flight reads and returns read data in order through a 4-entry buffer.
module spram_req_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int RAM_DEPTH    = 256,
   parameter int LB_RAM_DEPTH = $clog2(RAM_DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   spram_req_ctrl_if.slave         bus,
   output logic [DATA_WIDTH-1:0]   ram_din,
   output logic [LB_RAM_DEPTH-1:0] ram_addr,
   output logic                    ram_wr_en,
   input  logic [DATA_WIDTH-1:0]   ram_dout
);
   localparam int RSP_DEPTH = 4;

   logic                  accept;
   logic                  rd_accept;
   logic                  push;
   logic                  pop;
   logic [1:0]            rd_pipe;
   logic [2:0]            pending;
   logic [2:0]            count;
   logic [1:0]            wr_ptr;
   logic [1:0]            rd_ptr;
   logic [DATA_WIDTH-1:0] rsp_buf [RSP_DEPTH];

   // pending counts reads in flight plus buffered entries, so a granted read
   // always has a buffer slot waiting for it when its data returns.
   assign bus.req_ready = rst_n & (pending < 3'(RSP_DEPTH));
   assign accept        = bus.req_valid & bus.req_ready;
   assign rd_accept     = accept & ~bus.req_wr;

   assign ram_addr  = bus.req_addr;
   assign ram_din   = bus.req_wdata;
   assign ram_wr_en = accept & bus.req_wr;

   assign push          = rd_pipe[1];
   assign pop           = bus.rsp_valid & bus.rsp_ready;
   assign bus.rsp_valid = (count != 3'd0);
   assign bus.rsp_rdata = rsp_buf[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_pipe <= '0;
         pending <= '0;
         count   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         // NOTE: the buffer is only four words, so it is reset to give rsp_rdata a defined zero after reset.
         for (int i = 0; i < RSP_DEPTH; i++) rsp_buf[i] <= '0;
      end else begin
         rd_pipe <= {rd_pipe[0], rd_accept};

         if (push) begin
            rsp_buf[wr_ptr] <= ram_dout;
            wr_ptr          <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;

         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase

         case ({rd_accept, pop})
            2'b10:   pending <= pending + 3'd1;
            2'b01:   pending <= pending - 3'd1;
            default: pending <= pending;
         endcase
      end
   end

   // A full buffer can only take a push when the same cycle pops the head.
   assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (count == 3'(RSP_DEPTH)) && !pop));

endmodule

// File: tb/tb_spram_req_ctrl.sv
// Bench for spram_req_ctrl: 2-cycle RAM model, directed scenarios with literal
// expectations, and a randomized soak checked every cycle against a queue-based model.
module tb_spram_req_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] ram_din;
   logic [7:0] ram_addr;
   logic       ram_wr_en;
   logic [7:0] ram_dout;
   logic [7:0] ram_q1;
   bit   [7:0] ram_mem [256];

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: shadow memory, outstanding reads in request order, popped data.
   typedef struct {
      int         cyc;
      logic [7:0] data;
   } exp_t;
   bit   [7:0] shadow [256];
   exp_t       exp_q[$];
   logic [7:0] got_q[$];

   spram_req_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

   spram_req_ctrl #(.DATA_WIDTH(8), .RAM_DEPTH(256)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .ram_din   (ram_din),
      .ram_addr  (ram_addr),
      .ram_wr_en (ram_wr_en),
      .ram_dout  (ram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port RAM, address registered then output registered: 2-cycle read latency.
   always @(posedge clk) begin
      if (ram_wr_en) ram_mem[ram_addr] <= ram_din;
      ram_q1   <= ram_mem[ram_addr];
      ram_dout <= ram_q1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      logic exp_ready, exp_acc, exp_rv;
      if (!rst_n) begin
         check("req_ready_in_reset", bus.req_ready, 1'b0);
         exp_q.delete();
      end else begin
         exp_ready = (exp_q.size() < 4);
         exp_acc   = bus.req_valid && exp_ready;
         exp_rv    = (exp_q.size() > 0) && (exp_q[0].cyc + 3 <= cyc);
         check("req_ready", bus.req_ready, exp_ready);
         check("ram_wr_en", ram_wr_en, exp_acc && bus.req_wr);
         check("ram_addr",  ram_addr,  bus.req_addr);
         check("ram_din",   ram_din,   bus.req_wdata);
         check("rsp_valid", bus.rsp_valid, exp_rv);
         if (exp_rv) check("rsp_rdata", bus.rsp_rdata, exp_q[0].data);
         if (exp_rv && bus.rsp_ready) begin
            got_q.push_back(bus.rsp_rdata);
            void'(exp_q.pop_front());
         end
         if (exp_acc) begin
            if (bus.req_wr) shadow[bus.req_addr] = bus.req_wdata;
            else            exp_q.push_back('{cyc, shadow[bus.req_addr]});
         end
      end
   end

   // Drives one cycle starting at posedge+1; returns at the next posedge+1.
   task automatic cycle(input logic v, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input logic rr, output logic acc);
      bus.req_valid = v;
      bus.req_wr    = wr;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.rsp_ready = rr;
      @(negedge clk);
      acc = v & bus.req_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      logic acc;
      int   k = 0;
      while (exp_q.size() != 0 && k < 50) begin
         cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, acc);
         k++;
      end
      check("drain_timeout", k < 50, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      logic       acc;
      int         n_acc;
      logic [7:0] exp8;

      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rsp_valid", bus.rsp_valid, 1'b0);
      check("reset_rsp_rdata", bus.rsp_rdata, 8'h00);
      check("reset_req_ready", bus.req_ready, 1'b0);
      rst_n = 1'b1;
      #1;
      check("ready_after_reset", bus.req_ready, 1'b1);

      // 1: write 0xA5 @3 at t0, read @3 at t2 -> response in t5.
      got_q.delete();
      cycle(1'b1, 1'b1, 8'd3, 8'hA5, 1'b1, acc);
      cycle(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, acc);
      cycle(1'b1, 1'b0, 8'd3, 8'h00, 1'b1, acc);
      check("t1_valid_t3", bus.rsp_valid, 1'b0);
      cycle(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, acc);
      check("t1_valid_t4", bus.rsp_valid, 1'b0);
      cycle(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, acc);
      check("t1_valid_t5", bus.rsp_valid, 1'b1);
      check("t1_rdata_t5", bus.rsp_rdata, 8'hA5);
      drain();

      // 2: write 0x10..0x17 @0..7, then 8 back-to-back reads at full throughput.
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 8'(i), 8'(8'h10 + i), 1'b1, acc);
      got_q.delete();
      n_acc = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b0, 8'(i), 8'h00, 1'b1, acc);
         n_acc += int'(acc);
      end
      check("t2_reads_accepted", n_acc, 8);
      drain();
      check("t2_resp_count", got_q.size(), 8);
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         exp8 = 8'(8'h10 + i);
         check("t2_resp_data", got_q[i], exp8);
      end

      // 3: no consumer, reads @0..5: only 4 accepted until responses are taken.
      got_q.delete();
      n_acc = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b0, 8'(i), 8'h00, 1'b0, acc);
         n_acc += int'(acc);
      end
      check("t3_accepted", n_acc, 4);
      check("t3_ready_low", bus.req_ready, 1'b0);
      drain();
      cycle(1'b1, 1'b0, 8'd4, 8'h00, 1'b1, acc);
      check("t3_retry4_acc", acc, 1'b1);
      cycle(1'b1, 1'b0, 8'd5, 8'h00, 1'b1, acc);
      check("t3_retry5_acc", acc, 1'b1);
      drain();
      check("t3_resp_count", got_q.size(), 6);
      for (int i = 0; i < 6 && i < got_q.size(); i++) begin
         exp8 = 8'(8'h10 + i);
         check("t3_resp_data", got_q[i], exp8);
      end

      // 4: write then read same address on the next cycle returns new data.
      got_q.delete();
      cycle(1'b1, 1'b1, 8'd5, 8'h3C, 1'b1, acc);
      cycle(1'b1, 1'b0, 8'd5, 8'h00, 1'b1, acc);
      drain();
      check("t4_resp_count", got_q.size(), 1);
      if (got_q.size() > 0) check("t4_resp_data", got_q[0], 8'h3C);

      // 5: reset with two reads in flight: no stale responses afterwards.
      got_q.delete();
      cycle(1'b1, 1'b0, 8'd1, 8'h00, 1'b1, acc);
      cycle(1'b1, 1'b0, 8'd2, 8'h00, 1'b1, acc);
      rst_n = 1'b0;
      cycle(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, acc);
      rst_n = 1'b1;
      #1;
      check("t5_ready_first", bus.req_ready, 1'b1);
      check("t5_rdata_zero", bus.rsp_rdata, 8'h00);
      for (int i = 0; i < 6; i++) begin
         check("t5_no_stale", bus.rsp_valid, 1'b0);
         cycle(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, acc);
      end
      check("t5_got_none", got_q.size(), 0);

      // 6: top and bottom addresses are independent words.
      got_q.delete();
      cycle(1'b1, 1'b1, 8'd255, 8'hFF, 1'b1, acc);
      cycle(1'b1, 1'b1, 8'd0,   8'h01, 1'b1, acc);
      cycle(1'b1, 1'b0, 8'd255, 8'h00, 1'b1, acc);
      cycle(1'b1, 1'b0, 8'd0,   8'h00, 1'b1, acc);
      drain();
      check("t6_resp_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         check("t6_resp_top", got_q[0], 8'hFF);
         check("t6_resp_bot", got_q[1], 8'h01);
      end

      // Random soak: valid/ready/address mix, narrow address range for read-after-write hits.
      for (int i = 0; i < 1500; i++) begin
         cycle(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 4),
               ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)),
               8'($urandom), 1'($urandom_range(0, 9) < 7), acc);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
